// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding, op codes and byte-enable helper for dcache_main_fsm
// UNC_REQ/UNC_WAIT states exist only when DCACHE_UNCACHED_EN is defined.
package dcache_pkg;

    localparam int MAX_LINE_WORDS = 64;
    localparam int MAX_BE_W       = MAX_LINE_WORDS * 4;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOOKUP     = 3'd1,
        S_EVICT      = 3'd2,
        S_REFILL_REQ = 3'd3,
        S_REFILL     = 3'd4,
        S_WB_WAIT    = 3'd5
`ifdef DCACHE_UNCACHED_EN
        ,
        S_UNC_REQ    = 3'd6,
        S_UNC_WAIT   = 3'd7
`endif
    } state_t;

    // Four byte enables for word idx; callers truncate to their own line width.
    function automatic logic [MAX_BE_W-1:0] word_be(input int unsigned idx);
        logic [MAX_BE_W-1:0] w_one;
        w_one      = '0;
        w_one[3:0] = 4'hF;
        return w_one << (idx * 4);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - request, RAM-control and AXI-adapter signal bundle of dcache_main_fsm
// master = environment side, slave = controller side.
interface dcache_if #(
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int CW         = $clog2(LINE_WORDS)
);
    logic                    valid;
    logic                    op;
    logic                    uncached;
    logic                    cache_hit;
    logic [WAYS-1:0]         hit;
    logic [WAYS-1:0]         lru_way;
    logic                    victim_dirty;
    logic                    victim_valid;
    logic [LINE_WORDS*4-1:0] mem_we_normal;
    logic                    r_rdy;
    logic                    r_valid;
    logic                    w_rdy;
    logic                    w_done;

    logic [WAYS-1:0]         way_visit;
    logic                    mbuf_we;
    logic                    rbuf_we;
    logic                    wbuf_we;
    logic                    wbuf_reset;
    logic                    way_sel_en;
    logic                    rdata_sel;
    logic                    wrt_data_sel;
    logic [LINE_WORDS*4-1:0] mem_we;
    logic [WAYS-1:0]         mem_en;
    logic [WAYS-1:0]         tagv_we;
    logic [WAYS-1:0]         dirty_we;
    logic                    w_dirty_data;
    logic                    r_req;
    logic                    w_req;
    logic                    r_data_ready;
    logic                    unc_req;
    logic [CW-1:0]           fill_cnt;
    logic                    data_valid;
    logic                    busy;

    modport master (
        output valid, op, uncached, cache_hit, hit, lru_way, victim_dirty, victim_valid,
               mem_we_normal, r_rdy, r_valid, w_rdy, w_done,
        input  way_visit, mbuf_we, rbuf_we, wbuf_we, wbuf_reset, way_sel_en, rdata_sel,
               wrt_data_sel, mem_we, mem_en, tagv_we, dirty_we, w_dirty_data, r_req, w_req,
               r_data_ready, unc_req, fill_cnt, data_valid, busy
    );

    modport slave (
        input  valid, op, uncached, cache_hit, hit, lru_way, victim_dirty, victim_valid,
               mem_we_normal, r_rdy, r_valid, w_rdy, w_done,
        output way_visit, mbuf_we, rbuf_we, wbuf_we, wbuf_reset, way_sel_en, rdata_sel,
               wrt_data_sel, mem_we, mem_en, tagv_we, dirty_we, w_dirty_data, r_req, w_req,
               r_data_ready, unc_req, fill_cnt, data_valid, busy
    );

endinterface

// File: rtl/dcache_fill_counter.sv
// rtl/dcache_fill_counter.sv - refill beat counter with clear, enable and last-beat flag
// Wraps to zero after LINE_WORDS-1 because LINE_WORDS is a power of two.
module dcache_fill_counter #(
    parameter int LINE_WORDS = 16,
    parameter int CW         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/dcache_main_fsm.sv
// rtl/dcache_main_fsm.sv - write-back data cache main control FSM (lookup, evict, refill, write-back wait)
// Uncached single-word path built in with DCACHE_UNCACHED_EN.
module dcache_main_fsm
    import dcache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int CW         = $clog2(LINE_WORDS)
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);

    localparam int BE_W = LINE_WORDS * 4;
    typedef logic [BE_W-1:0] be_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_victim_was_dirty;
    logic          r_wb_done_seen;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_cnt_last;
    logic [CW-1:0] w_cnt;
    logic          w_wb_complete;
    be_t           w_beat_be;

    dcache_fill_counter #(
        .LINE_WORDS (LINE_WORDS),
        .CW         (CW)
    ) u_fill_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_last (w_cnt_last)
    );

    assign w_beat_be     = be_t'(word_be(32'(w_cnt)));
    assign w_wb_complete = !r_victim_was_dirty || bus.w_done || r_wb_done_seen;

`ifndef DCACHE_UNCACHED_EN
    logic w_unused_uncached;
    assign w_unused_uncached = bus.uncached;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_victim_was_dirty <= 1'b0;
            r_wb_done_seen     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOOKUP) begin
                r_victim_was_dirty <= bus.victim_dirty && bus.victim_valid;
            end
            // The write-back B response may beat the refill; remember it until WB_WAIT consumes it.
            if (r_state == S_WB_WAIT && w_wb_complete) begin
                r_wb_done_seen <= 1'b0;
            end else if (bus.w_done && (r_state == S_EVICT || r_state == S_REFILL_REQ ||
                                        r_state == S_REFILL)) begin
                r_wb_done_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_cnt_clr        = 1'b0;
        w_cnt_en         = 1'b0;
        bus.way_visit    = '0;
        bus.mbuf_we      = 1'b0;
        bus.rbuf_we      = 1'b0;
        bus.wbuf_we      = 1'b0;
        bus.wbuf_reset   = 1'b0;
        bus.way_sel_en   = 1'b0;
        bus.rdata_sel    = 1'b0;
        bus.wrt_data_sel = 1'b0;
        bus.mem_we       = '0;
        bus.mem_en       = '0;
        bus.tagv_we      = '0;
        bus.dirty_we     = '0;
        bus.w_dirty_data = 1'b0;
        bus.r_req        = 1'b0;
        bus.w_req        = 1'b0;
        bus.r_data_ready = 1'b0;
        bus.unc_req      = 1'b0;
        bus.fill_cnt     = '0;
        bus.data_valid   = 1'b0;
        bus.busy         = 1'b0;

        if (!rst) begin
            bus.busy     = (r_state != S_IDLE) && (r_state != S_LOOKUP);
            bus.fill_cnt = w_cnt;
            case (r_state)
                S_IDLE: begin
                    bus.rbuf_we = 1'b1;
                    if (bus.valid) w_next = S_LOOKUP;
                end
                S_LOOKUP: begin
                    bus.rdata_sel    = 1'b1;
                    bus.wrt_data_sel = 1'b1;
`ifdef DCACHE_UNCACHED_EN
                    if (bus.uncached) begin
                        bus.mbuf_we = 1'b1;
                        w_next      = S_UNC_REQ;
                    end else
`endif
                    if (bus.cache_hit) begin
                        bus.data_valid = 1'b1;
                        bus.rbuf_we    = 1'b1;
                        bus.way_sel_en = 1'b1;
                        bus.way_visit  = bus.hit;
                        if (bus.op == OP_WRITE) begin
                            bus.mem_en       = bus.hit;
                            bus.mem_we       = bus.mem_we_normal;
                            bus.dirty_we     = bus.hit;
                            bus.w_dirty_data = 1'b1;
                        end
                        w_next = bus.valid ? S_LOOKUP : S_IDLE;
                    end else begin
                        bus.mbuf_we = 1'b1;
                        bus.wbuf_we = 1'b1;
                        w_next = (bus.victim_dirty && bus.victim_valid) ? S_EVICT : S_REFILL_REQ;
                    end
                end
                S_EVICT: begin
                    bus.w_req = 1'b1;
                    if (bus.w_rdy) w_next = S_REFILL_REQ;
                end
                S_REFILL_REQ: begin
                    bus.r_req = 1'b1;
                    if (bus.r_rdy) begin
                        w_cnt_clr = 1'b1;
                        w_next    = S_REFILL;
                    end
                end
                S_REFILL: begin
                    bus.r_data_ready = 1'b1;
                    if (bus.r_valid) begin
                        bus.mem_en = bus.lru_way;
                        bus.mem_we = w_beat_be;
                        w_cnt_en   = 1'b1;
                        if (w_cnt_last) begin
                            bus.tagv_we      = bus.lru_way;
                            bus.dirty_we     = bus.lru_way;
                            bus.w_dirty_data = bus.op;
                            bus.way_sel_en   = 1'b1;
                            bus.way_visit    = bus.lru_way;
                            w_next           = S_WB_WAIT;
                        end
                    end
                end
                S_WB_WAIT: begin
                    if (w_wb_complete) begin
                        bus.data_valid = 1'b1;
                        bus.rbuf_we    = 1'b1;
                        bus.wbuf_reset = 1'b1;
                        w_next = bus.valid ? S_LOOKUP : S_IDLE;
                    end
                end
`ifdef DCACHE_UNCACHED_EN
                S_UNC_REQ: begin
                    bus.unc_req = 1'b1;
                    if (bus.op == OP_WRITE) begin
                        bus.w_req = 1'b1;
                        if (bus.w_rdy) w_next = S_UNC_WAIT;
                    end else begin
                        bus.r_req = 1'b1;
                        if (bus.r_rdy) w_next = S_UNC_WAIT;
                    end
                end
                S_UNC_WAIT: begin
                    bus.unc_req = 1'b1;
                    if (bus.op == OP_WRITE) begin
                        if (bus.w_done) begin
                            bus.data_valid = 1'b1;
                            w_next = bus.valid ? S_LOOKUP : S_IDLE;
                        end
                    end else begin
                        bus.r_data_ready = 1'b1;
                        if (bus.r_valid) begin
                            bus.rbuf_we    = 1'b1;
                            bus.data_valid = 1'b1;
                            w_next = bus.valid ? S_LOOKUP : S_IDLE;
                        end
                    end
                end
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

endmodule
